// File: rtl/dogx_startup_sequencer.sv
// Power-up/power-down sequencer for the DOGX front end: steps bandgap, DLL, DLL feedback
// and VCO-path enables with programmable settle times, then releases the converter.
//
// state    | meaning
// OFF      | everything off, waiting for en_s
// BG_UP    | bandgap settling
// DLL_UP   | DLL settling
// DLLFB_UP | DLL feedback settling
// VCO_UP   | selected VCO paths settling, converter held in reset
// SETTLE   | converter out of reset, output discarded
// RUN      | converter output valid
// HOLD     | enabled but no VCO path requested
// SD_CONV  | shutdown: VCOs and converter off
// SD_FB    | shutdown: DLL feedback off
// SD_DLL   | shutdown: DLL off
module dogx_startup_sequencer #(
    parameter int CNT_W    = 16,
    parameter int T_BG     = 2400,
    parameter int T_DLL    = 4800,
    parameter int T_DLLFB  = 240,
    parameter int T_VCO    = 480,
    parameter int T_SETTLE = 64
) (
    input  logic       CLK_24M,
    input  logic       reset,
    input  logic       en_req,
    input  logic       hsnr_req,
    input  logic       hdr_req,
    output logic       bg_en,
    output logic       dll_en,
    output logic       dll_fb_en,
    output logic       hsnr_en,
    output logic       hdr_en,
    output logic       conv_reset,
    output logic       ready,
    output logic [3:0] seq_state
);

    typedef enum logic [3:0] {
        OFF      = 4'd0,
        BG_UP    = 4'd1,
        DLL_UP   = 4'd2,
        DLLFB_UP = 4'd3,
        VCO_UP   = 4'd4,
        SETTLE   = 4'd5,
        RUN      = 4'd6,
        HOLD     = 4'd7,
        SD_CONV  = 4'd8,
        SD_FB    = 4'd9,
        SD_DLL   = 4'd10
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       path_q, path_d;
    logic [2:0]       sync1_q, sync2_q;
    logic [6:0]       out_q, out_d;

    logic       en_s;
    logic [1:0] req_s;
    logic       timer_done;
    logic       reload;
    logic       entering;

    assign en_s       = sync2_q[2];
    assign req_s      = sync2_q[1:0];
    assign timer_done = (cnt_q == '0);

    // Shutdown on en_s loss outranks any path change or timer expiry.
    always_comb begin
        state_d = state_q;
        reload  = 1'b0;
        if (!en_s && (state_q inside {BG_UP, DLL_UP, DLLFB_UP, VCO_UP, SETTLE, RUN, HOLD})) begin
            state_d = SD_CONV;
        end else begin
            case (state_q)
                OFF:      if (en_s) state_d = BG_UP;
                BG_UP:    if (timer_done) state_d = DLL_UP;
                DLL_UP:   if (timer_done) state_d = DLLFB_UP;
                DLLFB_UP: if (timer_done) state_d = (req_s != 2'b00) ? VCO_UP : HOLD;
                HOLD:     if (req_s != 2'b00) state_d = VCO_UP;
                VCO_UP, SETTLE, RUN: begin
                    if (req_s == 2'b00) begin
                        state_d = HOLD;
                    end else if (req_s != path_q) begin
                        state_d = VCO_UP;
                        reload  = 1'b1;
                    end else if (timer_done && state_q == VCO_UP) begin
                        state_d = SETTLE;
                    end else if (timer_done && state_q == SETTLE) begin
                        state_d = RUN;
                    end
                end
                SD_CONV:  state_d = SD_FB;
                SD_FB:    state_d = SD_DLL;
                SD_DLL:   state_d = OFF;
                default:  state_d = OFF;
            endcase
        end
    end

    assign entering = (state_d != state_q) || reload;

    always_comb begin
        cnt_d = timer_done ? cnt_q : cnt_q - CNT_W'(1);
        if (entering) begin
            case (state_d)
                BG_UP:    cnt_d = CNT_W'(T_BG - 1);
                DLL_UP:   cnt_d = CNT_W'(T_DLL - 1);
                DLLFB_UP: cnt_d = CNT_W'(T_DLLFB - 1);
                VCO_UP:   cnt_d = CNT_W'(T_VCO - 1);
                SETTLE:   cnt_d = CNT_W'(T_SETTLE - 1);
                default:  cnt_d = '0;
            endcase
        end
    end

    assign path_d = (entering && state_d == VCO_UP) ? req_s : path_q;

    // Outputs are decoded from the next state so they change on the same edge as the state.
    // Bit order: {bg, dll, dll_fb, hsnr, hdr, conv_reset, ready}.
    always_comb begin
        out_d = 7'b000_0000;
        case (state_d)
            BG_UP:          out_d = 7'b100_0000;
            DLL_UP:         out_d = 7'b110_0000;
            DLLFB_UP, HOLD: out_d = 7'b111_0000;
            VCO_UP:         out_d = {3'b111, path_d, 2'b00};
            SETTLE:         out_d = {3'b111, path_d, 2'b10};
            RUN:            out_d = {3'b111, path_d, 2'b11};
            SD_CONV:        out_d = 7'b111_0000;
            SD_FB:          out_d = 7'b110_0000;
            SD_DLL:         out_d = 7'b100_0000;
            default:        out_d = 7'b000_0000;
        endcase
    end

    always_ff @(posedge CLK_24M or negedge reset) begin
        if (!reset) begin
            state_q <= OFF;
            cnt_q   <= '0;
            path_q  <= 2'b00;
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
            out_q   <= 7'b000_0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            path_q  <= path_d;
            sync1_q <= {en_req, hsnr_req, hdr_req};
            sync2_q <= sync1_q;
            out_q   <= out_d;
        end
    end

    assign {bg_en, dll_en, dll_fb_en, hsnr_en, hdr_en, conv_reset, ready} = out_q;
    assign seq_state = state_q;

endmodule

// File: tb/tb_dogx_startup_sequencer.sv
// Bench for dogx_startup_sequencer: phase/elapsed-time model checked every cycle,
// plus literal edge-timed expectations for each scenario.
module tb_dogx_startup_sequencer;

    localparam int T_BG     = 4;
    localparam int T_DLL    = 8;
    localparam int T_DLLFB  = 2;
    localparam int T_VCO    = 3;
    localparam int T_SETTLE = 5;

    logic       CLK_24M;
    logic       reset;
    logic       en_req, hsnr_req, hdr_req;
    logic       bg_en, dll_en, dll_fb_en, hsnr_en, hdr_en, conv_reset, ready;
    logic [3:0] seq_state;

    int checks   = 0;
    int failures = 0;
    int cur      = 0;

    dogx_startup_sequencer #(
        .CNT_W(16), .T_BG(T_BG), .T_DLL(T_DLL), .T_DLLFB(T_DLLFB),
        .T_VCO(T_VCO), .T_SETTLE(T_SETTLE)
    ) dut (
        .CLK_24M(CLK_24M), .reset(reset),
        .en_req(en_req), .hsnr_req(hsnr_req), .hdr_req(hdr_req),
        .bg_en(bg_en), .dll_en(dll_en), .dll_fb_en(dll_fb_en),
        .hsnr_en(hsnr_en), .hdr_en(hdr_en), .conv_reset(conv_reset),
        .ready(ready), .seq_state(seq_state)
    );

    initial CLK_24M = 1'b0;
    always #5 CLK_24M = ~CLK_24M;

    // Model: phase number, cycles spent in phase, selected paths, two-stage input history.
    int         m_ph, m_el, m_nx;
    logic [1:0] m_path;
    logic [2:0] m_s1, m_s2;
    logic       m_rl;

    function automatic int dur(int ph);
        case (ph)
            1: return T_BG;
            2: return T_DLL;
            3: return T_DLLFB;
            4: return T_VCO;
            5: return T_SETTLE;
            default: return 0;
        endcase
    endfunction

    function automatic int model_next(int ph, int el, logic [2:0] s, logic [1:0] path);
        logic       en;
        logic [1:0] req;
        logic       up;
        en  = s[2];
        req = s[1:0];
        up  = (el >= dur(ph) - 1);
        if (ph >= 1 && ph <= 7 && !en) return 8;
        case (ph)
            0: return en ? 1 : 0;
            1, 2: return up ? ph + 1 : ph;
            3: return up ? ((req != 2'b00) ? 4 : 7) : 3;
            7: return (req != 2'b00) ? 4 : 7;
            4, 5, 6: begin
                if (req == 2'b00) return 7;
                if (req != path) return 4;
                if (ph != 6 && up) return ph + 1;
                return ph;
            end
            8, 9: return ph + 1;
            default: return 0;
        endcase
    endfunction

    function automatic logic [6:0] exp_out(int ph, logic [1:0] path);
        case (ph)
            1, 10:  return 7'b100_0000;
            2, 9:   return 7'b110_0000;
            3, 7, 8: return 7'b111_0000;
            4:      return {3'b111, path, 2'b00};
            5:      return {3'b111, path, 2'b10};
            6:      return {3'b111, path, 2'b11};
            default: return 7'b000_0000;
        endcase
    endfunction

    assign m_nx = model_next(m_ph, m_el, m_s2, m_path);
    assign m_rl = (m_ph >= 4 && m_ph <= 6 && m_s2[2] && m_s2[1:0] != 2'b00 && m_s2[1:0] != m_path);

    always @(posedge CLK_24M or negedge reset) begin
        if (!reset) begin
            m_ph   <= 0;
            m_el   <= 0;
            m_path <= 2'b00;
            m_s1   <= 3'b000;
            m_s2   <= 3'b000;
        end else begin
            m_ph <= m_nx;
            m_el <= (m_nx == m_ph && !m_rl) ? m_el + 1 : 0;
            if (m_nx == 4 && (m_ph != 4 || m_rl)) m_path <= m_s2[1:0];
            m_s2 <= m_s1;
            m_s1 <= {en_req, hsnr_req, hdr_req};
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [6:0] act_out();
        return {bg_en, dll_en, dll_fb_en, hsnr_en, hdr_en, conv_reset, ready};
    endfunction

    task automatic tick();
        @(posedge CLK_24M);
        #1;
        cur++;
        check("model_outputs", 32'(act_out()), 32'(exp_out(m_ph, m_path)));
        check("model_state", 32'(seq_state), 32'(m_ph));
    endtask

    task automatic to(int k);
        while (cur < k) tick();
    endtask

    task automatic mark();
        cur = 0;
    endtask

    initial begin
        reset = 1'b1; en_req = 1'b0; hsnr_req = 1'b0; hdr_req = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("reset_outputs", 32'(act_out()), 32'd0);
        check("reset_state", 32'(seq_state), 32'd0);
        tick(); tick(); tick();
        reset = 1'b1;

        // Startup: en + HSNR requested just after edge 0
        mark();
        en_req = 1'b1; hsnr_req = 1'b1;
        to(2);  check("start_bg_early", 32'(bg_en), 32'd0);
        to(3);  check("start_bg", 32'(bg_en), 32'd1);
                check("start_state_bg", 32'(seq_state), 32'd1);
        to(6);  check("start_dll_early", 32'(dll_en), 32'd0);
        to(7);  check("start_dll", 32'(dll_en), 32'd1);
        to(14); check("start_fb_early", 32'(dll_fb_en), 32'd0);
        to(15); check("start_fb", 32'(dll_fb_en), 32'd1);
        to(17); check("start_hsnr", 32'(hsnr_en), 32'd1);
                check("start_hdr_off", 32'(hdr_en), 32'd0);
                check("start_cr_vco", 32'(conv_reset), 32'd0);
        to(19); check("start_cr_early", 32'(conv_reset), 32'd0);
        to(20); check("start_cr", 32'(conv_reset), 32'd1);
                check("start_rdy_settle", 32'(ready), 32'd0);
        to(24); check("start_rdy_early", 32'(ready), 32'd0);
        to(25); check("start_rdy", 32'(ready), 32'd1);
                check("start_state_run", 32'(seq_state), 32'd6);

        // Shutdown from RUN
        to(28); en_req = 1'b0;
        to(30); check("sd_still_run", 32'(ready), 32'd1);
        to(31); check("sd_conv_state", 32'(seq_state), 32'd8);
                check("sd_conv_outs", 32'(act_out()), 32'b111_0000);
        to(32); check("sd_fb_state", 32'(seq_state), 32'd9);
                check("sd_fb_outs", 32'(act_out()), 32'b110_0000);
        to(33); check("sd_dll_outs", 32'(act_out()), 32'b100_0000);
        to(34); check("sd_off_state", 32'(seq_state), 32'd0);
                check("sd_off_outs", 32'(act_out()), 32'd0);

        // Reconfigure in RUN: add HDR
        mark();
        en_req = 1'b1;
        to(25); check("rcfg_run", 32'(ready), 32'd1);
        hdr_req = 1'b1;
        to(27); check("rcfg_pre", 32'(seq_state), 32'd6);
        to(28); check("rcfg_vco_state", 32'(seq_state), 32'd4);
                check("rcfg_vco_outs", 32'(act_out()), 32'b111_1100);
        to(35); check("rcfg_rdy_early", 32'(ready), 32'd0);
        to(36); check("rcfg_rdy", 32'(act_out()), 32'b111_1111);

        // No paths: park in HOLD, then request HSNR
        en_req = 1'b0; hsnr_req = 1'b0; hdr_req = 1'b0;
        to(44); check("np_off", 32'(seq_state), 32'd0);
        mark();
        en_req = 1'b1;
        to(17); check("np_hold_state", 32'(seq_state), 32'd7);
                check("np_hold_outs", 32'(act_out()), 32'b111_0000);
        to(20); check("np_hold_stays", 32'(seq_state), 32'd7);
        hsnr_req = 1'b1;
        to(22); check("np_hold_sync", 32'(seq_state), 32'd7);
        to(23); check("np_vco", 32'(seq_state), 32'd4);
        to(31); check("np_run_state", 32'(seq_state), 32'd6);
                check("np_run_outs", 32'(act_out()), 32'b111_1011);

        // Abort during DLL_UP, re-raise en while shutting down
        en_req = 1'b0;
        to(40); check("ab_off", 32'(seq_state), 32'd0);
        mark();
        en_req = 1'b1;
        to(8);  check("ab_dll", 32'(seq_state), 32'd2);
        en_req = 1'b0;
        to(10); check("ab_dll_hold", 32'(seq_state), 32'd2);
        en_req = 1'b1;
        to(11); check("ab_sdconv", 32'(seq_state), 32'd8);
        to(12); check("ab_sdfb", 32'(seq_state), 32'd9);
        to(13); check("ab_sddll", 32'(seq_state), 32'd10);
        to(14); check("ab_off2", 32'(seq_state), 32'd0);
                check("ab_off_bg", 32'(bg_en), 32'd0);
        to(15); check("ab_restart", 32'(seq_state), 32'd1);

        // Async reset in SETTLE
        to(33); check("ar_settle", 32'(seq_state), 32'd5);
        #3 reset = 1'b0;
        #1;
        check("ar_outs_zero", 32'(act_out()), 32'd0);
        check("ar_state_zero", 32'(seq_state), 32'd0);
        tick(); tick();
        reset = 1'b1;
        mark();
        to(2);  check("ar_bg_early", 32'(bg_en), 32'd0);
        to(3);  check("ar_bg", 32'(bg_en), 32'd1);
        to(7);  check("ar_dll", 32'(dll_en), 32'd1);
        to(15); check("ar_fb", 32'(dll_fb_en), 32'd1);
        to(17); check("ar_hsnr", 32'(hsnr_en), 32'd1);
        to(20); check("ar_cr", 32'(conv_reset), 32'd1);
        to(24); check("ar_rdy_early", 32'(ready), 32'd0);
        to(25); check("ar_rdy", 32'(ready), 32'd1);
        to(28);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
